// File: rtl/l2_refill_arbiter.sv
// Round-robin AR arbiter with a one-entry registered AR stage and index-routed R path for one L2 channel.
// Define CACHEPOOL_L2ARB_CREDIT_EN to add per-master in-flight burst counters capped at MaxOutstanding.
module l2_refill_arbiter #(
  parameter int NumMst         = 5,
  parameter int IdInWidth      = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 128,
  parameter int MaxOutstanding = 4,
  parameter int SelWidth       = $clog2(NumMst)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumMst-1:0]                     mst_ar_valid_i,
  output logic [NumMst-1:0]                     mst_ar_ready_o,
  input  logic [NumMst-1:0][AddrWidth-1:0]      mst_ar_addr_i,
  input  logic [NumMst-1:0][IdInWidth-1:0]      mst_ar_id_i,
  input  logic [NumMst-1:0][7:0]                mst_ar_len_i,
  output logic [NumMst-1:0]                     mst_r_valid_o,
  input  logic [NumMst-1:0]                     mst_r_ready_i,
  output logic [DataWidth-1:0]                  mst_r_data_o,
  output logic [IdInWidth-1:0]                  mst_r_id_o,
  output logic [1:0]                            mst_r_resp_o,
  output logic                                  mst_r_last_o,
  output logic                                  slv_ar_valid_o,
  input  logic                                  slv_ar_ready_i,
  output logic [AddrWidth-1:0]                  slv_ar_addr_o,
  output logic [IdInWidth+SelWidth-1:0]         slv_ar_id_o,
  output logic [7:0]                            slv_ar_len_o,
  input  logic                                  slv_r_valid_i,
  output logic                                  slv_r_ready_o,
  input  logic [DataWidth-1:0]                  slv_r_data_i,
  input  logic [IdInWidth+SelWidth-1:0]         slv_r_id_i,
  input  logic [1:0]                            slv_r_resp_i,
  input  logic                                  slv_r_last_i,
  output logic                                  idle_o,
  output logic                                  err_o
);
  localparam int IdOutWidth = IdInWidth + SelWidth;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // a valid source holds its payload stable until that edge, and ready never gates valid.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_e;

  stage_e                state_q, state_d;
  logic [SelWidth-1:0]   ptr_q;
  logic [SelWidth-1:0]   win, cand;
  logic [SelWidth:0]     wide;
  logic                  found, can_load, grant;
  logic [NumMst-1:0]     eligible;
  logic [AddrWidth-1:0]  addr_q;
  logic [IdOutWidth-1:0] id_q;
  logic [7:0]            len_q;
  logic [SelWidth-1:0]   r_sel;
  logic                  r_ok;

  assign can_load = (state_q == EMPTY) || slv_ar_ready_i;
  assign grant    = rst_ni && can_load && found;

  always_comb begin
    found = 1'b0;
    win   = '0;
    wide  = '0;
    cand  = '0;
    for (int i = 0; i < NumMst; i++) begin
      wide = {1'b0, ptr_q} + (SelWidth+1)'(i);
      if (wide >= (SelWidth+1)'(NumMst)) wide = wide - (SelWidth+1)'(NumMst);
      cand = wide[SelWidth-1:0];
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    mst_ar_ready_o = '0;
    if (grant) mst_ar_ready_o[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (grant)               state_d = FULL;
    else if (slv_ar_ready_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) ptr_q <= (win == SelWidth'(NumMst - 1)) ? '0 : win + 1'b1;
    end
  end

  // Payload needs no reset: it is only observed while the stage is FULL.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      addr_q <= mst_ar_addr_i[win];
      id_q   <= {win, mst_ar_id_i[win]};
      len_q  <= mst_ar_len_i[win];
    end
  end

  assign slv_ar_valid_o = (state_q == FULL);
  assign slv_ar_addr_o  = addr_q;
  assign slv_ar_id_o    = id_q;
  assign slv_ar_len_o   = len_q;

  assign r_sel = slv_r_id_i[IdOutWidth-1 -: SelWidth];
  assign r_ok  = int'(r_sel) < NumMst;

  // Beats carrying an index with no master behind it are swallowed so the channel never stalls.
  always_comb begin
    mst_r_valid_o = '0;
    slv_r_ready_o = 1'b1;
    if (r_ok) begin
      mst_r_valid_o[r_sel] = slv_r_valid_i;
      slv_r_ready_o        = mst_r_ready_i[r_sel];
    end
  end

  assign mst_r_data_o = slv_r_data_i;
  assign mst_r_id_o   = slv_r_id_i[IdInWidth-1:0];
  assign mst_r_resp_o = slv_r_resp_i;
  assign mst_r_last_o = slv_r_last_i;
  assign err_o        = rst_ni && slv_r_valid_i && !r_ok;

`ifdef CACHEPOOL_L2ARB_CREDIT_EN
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic [NumMst-1:0][CntWidth-1:0] cnt_q;
  logic [NumMst-1:0]               inc, dec;
  logic                            r_done;

  assign r_done = slv_r_valid_i && slv_r_ready_o && slv_r_last_i && r_ok;

  always_comb begin
    eligible = '0;
    inc      = '0;
    dec      = '0;
    for (int k = 0; k < NumMst; k++)
      eligible[k] = mst_ar_valid_i[k] && (cnt_q[k] < CntWidth'(MaxOutstanding));
    if (grant)  inc[win]   = 1'b1;
    if (r_done) dec[r_sel] = 1'b1;
  end

  // Saturating at zero absorbs last beats of bursts issued before a reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NumMst; k++) begin
        if (inc[k] && !dec[k])                        cnt_q[k] <= cnt_q[k] + 1'b1;
        else if (dec[k] && !inc[k] && cnt_q[k] != '0) cnt_q[k] <= cnt_q[k] - 1'b1;
      end
    end
  end

  assign idle_o = (state_q == EMPTY) && (cnt_q == '0);
`else
  assign eligible = mst_ar_valid_i;
  assign idle_o   = !slv_ar_valid_o;
`endif

endmodule
